// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control FSM with a small lap buffer.
// Routes either live time or a recalled lap to the display.
module stopwatch_lap_ctrl #(
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_btn_run,
    input  logic                         i_btn_clear,
    input  logic                         i_btn_lap,
    input  logic [6:0]                   msec,
    input  logic [6:0]                   sec,
    input  logic [6:0]                   min,
    input  logic [6:0]                   hour,
    output logic                         o_run,
    output logic                         o_clear,
    output logic [6:0]                   d_msec,
    output logic [6:0]                   d_sec,
    output logic [6:0]                   d_min,
    output logic [6:0]                   d_hour,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_cnt,
    output logic [$clog2(LAP_DEPTH)-1:0] o_view_idx,
    output logic                         o_lap_full,
    output logic                         o_lap_ovf
);

    localparam int IW = $clog2(LAP_DEPTH);
    localparam logic [IW:0] CNT_FULL = LAP_DEPTH[IW:0];

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CLEAR,
        ST_VIEW
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW:0]   lap_cnt;
    logic [IW:0]   lap_cnt_nx;
    logic [IW-1:0] view_idx;
    logic [IW-1:0] view_idx_nx;
    logic          ovf;
    logic          ovf_nx;
    logic          capture;
    logic          view_last;
    logic [27:0]   laps [LAP_DEPTH];
    logic [27:0]   shown;

    assign view_last = ({1'b0, view_idx} == (lap_cnt - 1'b1));

    // One button per cycle: run beats clear beats lap, even if the
    // winner is ignored in the current state.
    always_comb begin
        state_nx    = state;
        lap_cnt_nx  = lap_cnt;
        view_idx_nx = view_idx;
        ovf_nx      = 1'b0;
        capture     = 1'b0;
        unique case (state)
            ST_STOP: begin
                if (i_btn_run) begin
                    state_nx = ST_RUN;
                end else if (i_btn_clear) begin
                    state_nx    = ST_CLEAR;
                    lap_cnt_nx  = '0;
                    view_idx_nx = '0;
                end else if (i_btn_lap && lap_cnt != '0) begin
                    state_nx    = ST_VIEW;
                    view_idx_nx = '0;
                end
            end
            ST_RUN: begin
                if (i_btn_run) begin
                    state_nx = ST_STOP;
                end else if (i_btn_clear) begin
                    state_nx = ST_RUN;
                end else if (i_btn_lap) begin
                    if (lap_cnt == CNT_FULL) begin
                        ovf_nx = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        lap_cnt_nx = lap_cnt + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_nx = ST_STOP;
            end
            ST_VIEW: begin
                if (i_btn_run) begin
                    state_nx = ST_STOP;
                end else if (i_btn_clear) begin
                    state_nx    = ST_CLEAR;
                    lap_cnt_nx  = '0;
                    view_idx_nx = '0;
                end else if (i_btn_lap) begin
                    view_idx_nx = view_last ? '0 : view_idx + 1'b1;
                end
            end
            default: begin
                state_nx = ST_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_STOP;
            lap_cnt  <= '0;
            view_idx <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nx;
            lap_cnt  <= lap_cnt_nx;
            view_idx <= view_idx_nx;
            ovf      <= ovf_nx;
        end
    end

    // Storage needs no reset: lap_cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            laps[lap_cnt[IW-1:0]] <= {hour, min, sec, msec};
        end
    end

    assign shown = (state == ST_VIEW) ? laps[view_idx]
                                      : {hour, min, sec, msec};

    assign o_run      = (state == ST_RUN);
    assign o_clear    = (state == ST_CLEAR);
    assign o_lap_cnt  = lap_cnt;
    assign o_view_idx = view_idx;
    assign o_lap_full = (lap_cnt == CNT_FULL);
    assign o_lap_ovf  = ovf;
    assign d_hour     = shown[27:21];
    assign d_min      = shown[20:14];
    assign d_sec      = shown[13:7];
    assign d_msec     = shown[6:0];

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Testbench for stopwatch_lap_ctrl: vector table, corner sequences,
// and random stimulus against a queue-based lap model.
module tb_stopwatch_lap_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [6:0] msec = '0;
    logic [6:0] sec = '0;
    logic [6:0] min = '0;
    logic [6:0] hour = '0;
    logic       o_run;
    logic       o_clear;
    logic [6:0] d_msec;
    logic [6:0] d_sec;
    logic [6:0] d_min;
    logic [6:0] d_hour;
    logic [2:0] o_lap_cnt;
    logic [1:0] o_view_idx;
    logic       o_lap_full;
    logic       o_lap_ovf;

    int n_chk = 0;
    int n_fail = 0;

    stopwatch_lap_ctrl #(.LAP_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_btn_run  (btn_run),
        .i_btn_clear(btn_clear),
        .i_btn_lap  (btn_lap),
        .msec       (msec),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .o_run      (o_run),
        .o_clear    (o_clear),
        .d_msec     (d_msec),
        .d_sec      (d_sec),
        .d_min      (d_min),
        .d_hour     (d_hour),
        .o_lap_cnt  (o_lap_cnt),
        .o_view_idx (o_view_idx),
        .o_lap_full (o_lap_full),
        .o_lap_ovf  (o_lap_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of buttons/live time; return #1 after the edge.
    task automatic cyc(input bit r, input bit c, input bit l,
                       input int ms, input int s,
                       input int m, input int h);
        @(negedge clk);
        btn_run   = r;
        btn_clear = c;
        btn_lap   = l;
        msec = 7'(ms);
        sec  = 7'(s);
        min  = 7'(m);
        hour = 7'(h);
        @(posedge clk);
        #1;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Behavioural model: mode names, a queue of lap values.
    localparam int M_STOP = 0, M_RUN = 1, M_CLR = 2, M_VIEW = 3;
    int m_mode;
    int m_laps[$];
    int m_vidx;
    bit m_ovf;

    function automatic void m_reset();
        m_mode = M_STOP;
        m_laps.delete();
        m_vidx = 0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void m_step(bit r, bit c, bit l, int live);
        bit ovf_n = 1'b0;
        case (m_mode)
            M_STOP:
                if (r) m_mode = M_RUN;
                else if (c) begin
                    m_mode = M_CLR;
                    m_laps.delete();
                    m_vidx = 0;
                end else if (l && m_laps.size() > 0) begin
                    m_mode = M_VIEW;
                    m_vidx = 0;
                end
            M_RUN:
                if (r) m_mode = M_STOP;
                else if (!c && l) begin
                    if (m_laps.size() == DEPTH) ovf_n = 1'b1;
                    else m_laps.push_back(live);
                end
            M_CLR:
                m_mode = M_STOP;
            default:
                if (r) m_mode = M_STOP;
                else if (c) begin
                    m_mode = M_CLR;
                    m_laps.delete();
                    m_vidx = 0;
                end else if (l) begin
                    m_vidx = (m_vidx + 1) % m_laps.size();
                end
        endcase
        m_ovf = ovf_n;
    endfunction

    typedef struct {
        bit r;
        bit c;
        bit l;
        int ms;
        int s;
        int e_run;
        int e_clr;
        int e_cnt;
        int e_idx;
        int e_full;
        int e_dms;
        int e_ds;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1,0,0,  0, 0, 1,0,0,0,0,  0, 0};
        tbl[1]  = '{0,0,1, 12, 5, 1,0,1,0,0, 12, 5};
        tbl[2]  = '{0,1,0, 20, 7, 1,0,1,0,0, 20, 7};
        tbl[3]  = '{0,0,1, 40, 9, 1,0,2,0,0, 40, 9};
        tbl[4]  = '{1,0,0, 41, 9, 0,0,2,0,0, 41, 9};
        tbl[5]  = '{0,0,1, 55,33, 0,0,2,0,0, 12, 5};
        tbl[6]  = '{0,0,1, 56,33, 0,0,2,1,0, 40, 9};
        tbl[7]  = '{0,0,1, 57,33, 0,0,2,0,0, 12, 5};
        tbl[8]  = '{0,0,1, 58,33, 0,0,2,1,0, 40, 9};
        tbl[9]  = '{1,0,0, 60, 1, 0,0,2,1,0, 60, 1};
        tbl[10] = '{1,1,0, 61, 1, 1,0,2,1,0, 61, 1};
        tbl[11] = '{1,0,0, 62, 1, 0,0,2,1,0, 62, 1};
        tbl[12] = '{0,0,1, 63, 1, 0,0,2,0,0, 12, 5};
        tbl[13] = '{0,1,0, 64, 1, 0,1,0,0,0, 64, 1};
        tbl[14] = '{0,0,0, 65, 1, 0,0,0,0,0, 65, 1};
        tbl[15] = '{0,0,1, 66, 1, 0,0,0,0,0, 66, 1};

        do_reset();
        chk("rst_run", o_run, 0);
        chk("rst_clear", o_clear, 0);
        chk("rst_cnt", o_lap_cnt, 0);
        chk("rst_full", o_lap_full, 0);
        chk("rst_ovf", o_lap_ovf, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].r, tbl[i].c, tbl[i].l, tbl[i].ms, tbl[i].s, 0, 0);
            chk($sformatf("v%0d_run", i), o_run, tbl[i].e_run);
            chk($sformatf("v%0d_clear", i), o_clear, tbl[i].e_clr);
            chk($sformatf("v%0d_cnt", i), o_lap_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d_idx", i), o_view_idx, tbl[i].e_idx);
            chk($sformatf("v%0d_full", i), o_lap_full, tbl[i].e_full);
            chk($sformatf("v%0d_ovf", i), o_lap_ovf, 0);
            chk($sformatf("v%0d_dms", i), d_msec, tbl[i].e_dms);
            chk($sformatf("v%0d_ds", i), d_sec, tbl[i].e_ds);
        end

        // Overflow: five laps into a four-entry buffer.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, i + 1, i, 2, 1);
            chk($sformatf("ovf_ok%0d", i), o_lap_ovf, 0);
        end
        chk("full_cnt", o_lap_cnt, 4);
        chk("full_flag", o_lap_full, 1);
        cyc(0, 0, 1, 99, 59, 59, 9);
        chk("ovf_pulse", o_lap_ovf, 1);
        chk("ovf_cnt", o_lap_cnt, 4);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_drop", o_lap_ovf, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 0, 0);
        chk("e3_idx", o_view_idx, 3);
        chk("e3_ms", d_msec, 4);
        chk("e3_s", d_sec, 3);
        chk("e3_h", d_hour, 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        chk("wrap_idx", o_view_idx, 0);
        chk("wrap_ms", d_msec, 1);

        // Asynchronous reset mid-run with three laps.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, i, i, 0, 0);
        chk("pre_arst_cnt", o_lap_cnt, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_run", o_run, 0);
        chk("arst_cnt", o_lap_cnt, 0);
        chk("arst_idx", o_view_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("first_pulse", o_run, 1);

        // Random stimulus against the model.
        do_reset();
        m_reset();
        for (int i = 0; i < 1500; i++) begin
            bit r, c, l;
            int ms, s, mn, h, live, exp_d;
            r  = ($urandom_range(0, 99) < 15);
            c  = ($urandom_range(0, 99) < 10);
            l  = ($urandom_range(0, 99) < 45);
            ms = $urandom_range(0, 99);
            s  = $urandom_range(0, 59);
            mn = $urandom_range(0, 59);
            h  = $urandom_range(0, 99);
            live = (h << 21) | (mn << 14) | (s << 7) | ms;
            cyc(r, c, l, ms, s, mn, h);
            m_step(r, c, l, live);
            exp_d = (m_mode == M_VIEW) ? m_laps[m_vidx] : live;
            chk("rnd_run", o_run, m_mode == M_RUN);
            chk("rnd_clear", o_clear, m_mode == M_CLR);
            chk("rnd_cnt", o_lap_cnt, m_laps.size());
            chk("rnd_idx", o_view_idx, m_vidx);
            chk("rnd_full", o_lap_full, m_laps.size() == DEPTH);
            chk("rnd_ovf", o_lap_ovf, m_ovf);
            chk("rnd_disp", {d_hour, d_min, d_sec, d_msec}, exp_d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
